// File: rtl/mips_run_ctrl_if.sv
// Bundle between the run controller and its host: start/pc in, core reset and run status out.
interface mips_run_ctrl_if #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
);
   logic             start;
   logic [PC_W-1:0]  pc;
   logic             cpu_reset;
   logic             running;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] cycle_cnt;
   logic [CNT_W-1:0] retire_cnt;

   modport master (
      output start, pc,
      input  cpu_reset, running, done, timeout, cycle_cnt, retire_cnt
   );

   modport slave (
      input  start, pc,
      output cpu_reset, running, done, timeout, cycle_cnt, retire_cnt
   );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: sequences core reset, counts cycles and
// retired instructions, and ends the run on a halt PC, a PC self-loop or a cycle timeout.
module mips_run_ctrl #(
   parameter int              PC_W         = 32,
   parameter int              CNT_W        = 32,
   parameter int              RESET_CYCLES = 4,
   parameter logic [PC_W-1:0] HALT_PC      = PC_W'(32'h0000_3FFC),
   parameter int              HALT_REPEAT  = 3,
   parameter int              MAX_CYCLES   = 100000,
   parameter bit              AUTO_START   = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   mips_run_ctrl_if.slave  bus
);

   localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
   localparam int SAME_W = $clog2(HALT_REPEAT + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HOLD,
      ST_RUN,
      ST_DONE,
      ST_TOUT
   } state_t;

   state_t            state_q, state_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              running_q, running_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [SAME_W-1:0] same_cnt_q, same_cnt_d;
   logic [PC_W-1:0]   prev_pc_q, prev_pc_d;
   logic              first_q, first_d;

   logic go_hold;
   logic pc_same;
   logic halt_hit;
   logic tout_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   always_comb begin
      state_d      = state_q;
      cpu_reset_d  = cpu_reset_q;
      running_d    = running_q;
      done_d       = done_q;
      timeout_d    = timeout_q;
      cycle_cnt_d  = cycle_cnt_q;
      retire_cnt_d = retire_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      same_cnt_d   = same_cnt_q;
      prev_pc_d    = prev_pc_q;
      first_d      = first_q;
      go_hold      = 1'b0;
      pc_same      = (bus.pc == prev_pc_q);
      halt_hit     = 1'b0;
      tout_hit     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cpu_reset_d = 1'b1;
            running_d   = 1'b0;
            if (AUTO_START || bus.start) go_hold = 1'b1;
         end

         ST_HOLD: begin
            if (hold_cnt_q == HOLD_W'(RESET_CYCLES - 1)) begin
               state_d     = ST_RUN;
               cpu_reset_d = 1'b0;
               running_d   = 1'b1;
               first_d     = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end

         ST_RUN: begin
            prev_pc_d = bus.pc;
            first_d   = 1'b0;
            // The first RUN sample only seeds prev_pc; retire/halt logic starts afterwards.
            if (!first_q) begin
               if (!pc_same) begin
                  retire_cnt_d = sat_inc(retire_cnt_q);
                  same_cnt_d   = '0;
               end else if (same_cnt_q != '1) begin
                  same_cnt_d = same_cnt_q + 1'b1;
               end
               halt_hit = (bus.pc == HALT_PC) ||
                          (pc_same && (int'(same_cnt_q) + 1 >= HALT_REPEAT - 1));
            end
            tout_hit = (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1));

            if (halt_hit) begin
               state_d     = ST_DONE;
               done_d      = 1'b1;
               running_d   = 1'b0;
               cycle_cnt_d = sat_inc(cycle_cnt_q);
            end else if (tout_hit) begin
               // The cycle counter stops at MAX_CYCLES-1 on a timeout.
               state_d   = ST_TOUT;
               timeout_d = 1'b1;
               running_d = 1'b0;
            end else begin
               cycle_cnt_d = sat_inc(cycle_cnt_q);
            end
         end

         ST_DONE, ST_TOUT: begin
            if (bus.start) go_hold = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (go_hold) begin
         state_d      = ST_HOLD;
         cpu_reset_d  = 1'b1;
         running_d    = 1'b0;
         done_d       = 1'b0;
         timeout_d    = 1'b0;
         cycle_cnt_d  = '0;
         retire_cnt_d = '0;
         hold_cnt_d   = '0;
         same_cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         cpu_reset_q  <= 1'b1;
         running_q    <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         cycle_cnt_q  <= '0;
         retire_cnt_q <= '0;
         hold_cnt_q   <= '0;
         same_cnt_q   <= '0;
         prev_pc_q    <= '0;
         first_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cpu_reset_q  <= cpu_reset_d;
         running_q    <= running_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         cycle_cnt_q  <= cycle_cnt_d;
         retire_cnt_q <= retire_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         same_cnt_q   <= same_cnt_d;
         prev_pc_q    <= prev_pc_d;
         first_q      <= first_d;
      end
   end

   assign bus.cpu_reset  = cpu_reset_q;
   assign bus.running    = running_q;
   assign bus.done       = done_q;
   assign bus.timeout    = timeout_q;
   assign bus.cycle_cnt  = cycle_cnt_q;
   assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: default instance for sequencing/halt/restart/async reset,
// plus MAX_CYCLES=20 and MAX_CYCLES=10 instances for timeout and halt-vs-timeout priority.
module tb_mips_run_ctrl;

   localparam logic [31:0] HALT = 32'h0000_3FFC;

   logic clk = 1'b0;
   logic rst_n;
   logic rst_bc_n;

   always #5 clk = ~clk;

   mips_run_ctrl_if ifa ();
   mips_run_ctrl_if ifb ();
   mips_run_ctrl_if ifc ();

   mips_run_ctrl dut_a (
      .clk   (clk),
      .reset (rst_n),
      .bus   (ifa.slave)
   );

   mips_run_ctrl #(.MAX_CYCLES(20)) dut_b (
      .clk   (clk),
      .reset (rst_bc_n),
      .bus   (ifb.slave)
   );

   mips_run_ctrl #(.MAX_CYCLES(10)) dut_c (
      .clk   (clk),
      .reset (rst_bc_n),
      .bus   (ifc.slave)
   );

   typedef struct {
      logic        done;
      logic        tout;
      logic [31:0] retire;
      logic [31:0] cycles;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] seq[$];
   int          checks = 0;
   int          errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input logic d, input logic t, input logic [31:0] r, input logic [31:0] c);
      exp_t e;
      e.done = d; e.tout = t; e.retire = r; e.cycles = c;
      sb_q.push_back(e);
   endtask

   task automatic sb_compare(input string who, input logic d, input logic t,
                             input logic [31:0] r, input logic [31:0] c);
      exp_t e;
      check_val({who, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         $display("run %s ended: done=%0d timeout=%0d retire=%0d cycles=%0d", who, d, t, r, c);
         check_val({who, "_done"},    d, e.done);
         check_val({who, "_timeout"}, t, e.tout);
         check_val({who, "_retire"},  r, e.retire);
         check_val({who, "_cycles"},  c, e.cycles);
      end
   endtask

   // Drive seq[] into dut_a one value per RUN cycle, then score the ended run.
   task automatic run_a(input string who);
      int n = 0;
      while (!ifa.running && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val({who, "_run_start"}, ifa.running, 1'b1);
      foreach (seq[i]) begin
         ifa.pc = seq[i];
         @(negedge clk);
      end
      n = 0;
      while (ifa.running && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_val({who, "_run_end"}, ifa.running, 1'b0);
      check_val({who, "_cpu_reset_low"}, ifa.cpu_reset, 1'b0);
      sb_compare(who, ifa.done, ifa.timeout, ifa.retire_cnt, ifa.cycle_cnt);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  b_open, c_open;

      rst_n = 1'b0; rst_bc_n = 1'b0;
      ifa.start = 1'b0; ifa.pc = '0;
      ifb.start = 1'b0; ifb.pc = '0;
      ifc.start = 1'b0; ifc.pc = '0;

      // Reset values and release latency
      repeat (3) @(negedge clk);
      check_val("rst_cpu_reset", ifa.cpu_reset, 1'b1);
      check_val("rst_running", ifa.running, 1'b0);
      check_val("rst_done", ifa.done, 1'b0);
      check_val("rst_timeout", ifa.timeout, 1'b0);
      check_val("rst_cycle", ifa.cycle_cnt, 32'd0);
      rst_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check_val($sformatf("lat_cpu_reset_e%0d", k), ifa.cpu_reset, (k < 5) ? 1'b1 : 1'b0);
         check_val($sformatf("lat_running_e%0d", k), ifa.running, (k == 5) ? 1'b1 : 1'b0);
      end
      $display("reset release: RUN after 5 edges");

      // Halt PC ends the run
      seq.delete();
      for (int i = 0; i < 5; i++) seq.push_back(32'h3000 + 32'(4 * i));
      seq.push_back(HALT);
      sb_push(1'b1, 1'b0, 32'd5, 32'd6);
      run_a("halt_pc");

      // Restart from DONE: counters clear, 4-cycle HOLD
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      check_val("restart_done_clr", ifa.done, 1'b0);
      check_val("restart_cycle_clr", ifa.cycle_cnt, 32'd0);
      check_val("restart_retire_clr", ifa.retire_cnt, 32'd0);
      check_val("restart_cpu_reset", ifa.cpu_reset, 1'b1);
      n = 0;
      while (!ifa.running && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("restart_hold_edges", 64'(n), 64'd4);
      $display("restart: HOLD edges=%0d", n);

      // Self-loop ends the run
      seq.delete();
      for (int i = 0; i < 3; i++) seq.push_back(32'h3000 + 32'(4 * i));
      seq.push_back(32'h3008);
      seq.push_back(32'h3008);
      sb_push(1'b1, 1'b0, 32'd2, 32'd5);
      run_a("self_loop");

      // Asynchronous reset in the middle of a run
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
      n = 0;
      while (!ifa.running && n < 20) begin
         @(negedge clk);
         n++;
      end
      ifa.pc = 32'h3000;
      @(negedge clk);
      ifa.pc = 32'h3004;
      @(negedge clk);
      check_val("mid_running", ifa.running, 1'b1);
      check_val("mid_retire", ifa.retire_cnt, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("async_cpu_reset", ifa.cpu_reset, 1'b1);
      check_val("async_running", ifa.running, 1'b0);
      check_val("async_cycle", ifa.cycle_cnt, 32'd0);
      check_val("async_retire", ifa.retire_cnt, 32'd0);
      $display("async reset mid-run: cpu_reset=%0d running=%0d", ifa.cpu_reset, ifa.running);
      @(negedge clk);
      rst_n = 1'b1;

      // Timeout (dut_b, MAX 20) and halt-on-timeout-cycle (dut_c, MAX 10), run together
      sb_push(1'b1, 1'b0, 32'd9, 32'd10);
      sb_push(1'b0, 1'b1, 32'd19, 32'd19);
      rst_bc_n = 1'b1;
      n = 0;
      while (!ifb.running && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("bc_run_start", ifb.running & ifc.running, 1'b1);
      b_open = 1'b1;
      c_open = 1'b1;
      for (int i = 0; i < 40 && (b_open || c_open); i++) begin
         ifb.pc = 32'h100 + 32'(4 * i);
         ifc.pc = (i == 9) ? HALT : 32'h100 + 32'(4 * i);
         @(negedge clk);
         if (c_open && !ifc.running) begin
            sb_compare("halt_vs_tout", ifc.done, ifc.timeout, ifc.retire_cnt, ifc.cycle_cnt);
            c_open = 1'b0;
         end
         if (b_open && !ifb.running) begin
            sb_compare("timeout", ifb.done, ifb.timeout, ifb.retire_cnt, ifb.cycle_cnt);
            b_open = 1'b0;
         end
      end
      check_val("bc_finished", 64'(b_open || c_open), 64'd0);
      repeat (3) @(negedge clk);
      check_val("tout_sticky", ifb.timeout, 1'b1);
      check_val("tout_cycle_frozen", ifb.cycle_cnt, 32'd19);
      check_val("done_sticky", ifc.done, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
